// File: rtl/cond_exec_unit.sv
// cond_exec_unit: NZCV flag register, condition-code gating of control enables
// and an optional IT-style predication block, built in when COND_PRED_EN is defined.
module cond_exec_unit #(
    parameter int NUM_CTRL = 3,
    parameter int PRED_MAX = 4,
    localparam int CNT_W = $clog2(PRED_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [3:0]          cond_i,
    input  logic [3:0]          alu_flags_i,
    input  logic [1:0]          flag_write_i,
    input  logic [NUM_CTRL-1:0] ctrl_i,
    input  logic                pred_start_i,
    input  logic [3:0]          pred_cond_i,
    input  logic [CNT_W-1:0]    pred_len_i,
    output logic [NUM_CTRL-1:0] ctrl_o,
    output logic                cond_ex_o,
    output logic [3:0]          flags_o,
    output logic                pred_active_o,
    output logic [CNT_W-1:0]    pred_remaining_o,
    output logic                pred_err_o
);

    // Flag vector layout is {Z,C,N,V}
    localparam int Z_B = 3;
    localparam int C_B = 2;
    localparam int N_B = 1;
    localparam int V_B = 0;

    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] NE = 4'h1;
    localparam logic [3:0] CS = 4'h2;
    localparam logic [3:0] CC = 4'h3;
    localparam logic [3:0] MI = 4'h4;
    localparam logic [3:0] PL = 4'h5;
    localparam logic [3:0] VS = 4'h6;
    localparam logic [3:0] VC = 4'h7;
    localparam logic [3:0] HI = 4'h8;
    localparam logic [3:0] LS = 4'h9;
    localparam logic [3:0] GE = 4'hA;
    localparam logic [3:0] LT = 4'hB;
    localparam logic [3:0] GT = 4'hC;
    localparam logic [3:0] LE = 4'hD;
    localparam logic [3:0] AL = 4'hE;

    function automatic logic cond_pass(
        input logic [3:0] code,
        input logic [3:0] f
    );
        logic z;
        logic c;
        logic n;
        logic v;
        logic ge;
        z  = f[Z_B];
        c  = f[C_B];
        n  = f[N_B];
        v  = f[V_B];
        ge = (n == v);
        unique case (code)
            EQ:      cond_pass = z;
            NE:      cond_pass = ~z;
            CS:      cond_pass = c;
            CC:      cond_pass = ~c;
            MI:      cond_pass = n;
            PL:      cond_pass = ~n;
            VS:      cond_pass = v;
            VC:      cond_pass = ~v;
            HI:      cond_pass = c & ~z;
            LS:      cond_pass = ~c | z;
            GE:      cond_pass = ge;
            LT:      cond_pass = ~ge;
            GT:      cond_pass = ~z & ge;
            LE:      cond_pass = z | ~ge;
            AL:      cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] eff_cond;
    logic       marker;
    logic       exec;

    // A marker that opens a block only sets up state; it never executes itself
    assign exec      = valid_i & cond_pass(eff_cond, flags_q) & ~marker;
    assign cond_ex_o = exec;
    assign ctrl_o    = ctrl_i & {NUM_CTRL{exec}};
    assign flags_o   = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (exec) begin
            if (flag_write_i[1]) begin
                flags_d[Z_B] = alu_flags_i[Z_B];
                flags_d[N_B] = alu_flags_i[N_B];
            end
            if (flag_write_i[0]) begin
                flags_d[C_B] = alu_flags_i[C_B];
                flags_d[V_B] = alu_flags_i[V_B];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_PRED_EN

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PRED_MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       pcond_q;
    logic [3:0]       pcond_d;
    logic             err_q;
    logic             err_d;
    logic             block_on;
    logic [CNT_W-1:0] len_clip;

    assign block_on = (state_q == ACTIVE);
    assign marker   = valid_i & pred_start_i & ~block_on;
    assign eff_cond = block_on ? pcond_q : cond_i;
    assign len_clip = (pred_len_i > LEN_MAX) ? LEN_MAX : pred_len_i;

    assign pred_active_o    = block_on;
    assign pred_remaining_o = count_q;
    assign pred_err_o       = err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pcond_d = pcond_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (marker && (pred_len_i != '0)) begin
                    state_d = ACTIVE;
                    count_d = len_clip;
                    pcond_d = pred_cond_i;
                end
            end
            ACTIVE: begin
                // Nested markers take a slot but never reload the block
                err_d = valid_i & pred_start_i;
                if (valid_i) begin
                    count_d = count_q - ONE;
                    if (count_q == ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pcond_q <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pcond_q <= pcond_d;
            err_q   <= err_d;
        end
    end

`else

    logic unused_pred;

    assign unused_pred      = ^{pred_start_i, pred_cond_i, pred_len_i};
    assign marker           = 1'b0;
    assign eff_cond         = cond_i;
    assign pred_active_o    = 1'b0;
    assign pred_remaining_o = '0;
    assign pred_err_o       = 1'b0;

`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
// Testbench for cond_exec_unit: directed steps plus random traffic,
// checked against an instruction-level model of flags and predication.
module tb_cond_exec_unit;

    localparam int NUM_CTRL = 3;
    localparam int PRED_MAX = 4;
    localparam int CNT_W    = 3;
`ifdef COND_PRED_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                valid_i;
    logic [3:0]          cond_i;
    logic [3:0]          alu_flags_i;
    logic [1:0]          flag_write_i;
    logic [NUM_CTRL-1:0] ctrl_i;
    logic                pred_start_i;
    logic [3:0]          pred_cond_i;
    logic [CNT_W-1:0]    pred_len_i;
    logic [NUM_CTRL-1:0] ctrl_o;
    logic                cond_ex_o;
    logic [3:0]          flags_o;
    logic                pred_active_o;
    logic [CNT_W-1:0]    pred_remaining_o;
    logic                pred_err_o;

    cond_exec_unit #(
        .NUM_CTRL(NUM_CTRL),
        .PRED_MAX(PRED_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .cond_i          (cond_i),
        .alu_flags_i     (alu_flags_i),
        .flag_write_i    (flag_write_i),
        .ctrl_i          (ctrl_i),
        .pred_start_i    (pred_start_i),
        .pred_cond_i     (pred_cond_i),
        .pred_len_i      (pred_len_i),
        .ctrl_o          (ctrl_o),
        .cond_ex_o       (cond_ex_o),
        .flags_o         (flags_o),
        .pred_active_o   (pred_active_o),
        .pred_remaining_o(pred_remaining_o),
        .pred_err_o      (pred_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: flags as separate bits, block as "instructions left"
    bit mz, mc, mn, mv;
    bit m_act;
    int m_left;
    int m_pc;
    bit m_err;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Even codes name a base predicate, odd codes its negation; 15 never runs
    function automatic bit m_pass(input int code);
        bit base;
        bit ge;
        ge = (mn == mv);
        case (code / 2)
            0:       base = mz;
            1:       base = mc;
            2:       base = mn;
            3:       base = mv;
            4:       base = mc && !mz;
            5:       base = ge;
            6:       base = !mz && ge;
            default: base = 1'b1;
        endcase
        if (code == 15) return 1'b0;
        return (code % 2 == 1) ? !base : base;
    endfunction

    task automatic cycle(input bit rst, input bit v, input int c,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic [2:0] ctl, input bit ps,
                         input int pc, input int pl);
        int eff;
        bit mark;
        bit ex;
        bit err_n;
        @(negedge clk);
        reset        = rst;
        valid_i      = v;
        cond_i       = 4'(c);
        alu_flags_i  = af;
        flag_write_i = fw;
        ctrl_i       = ctl;
        pred_start_i = ps;
        pred_cond_i  = 4'(pc);
        pred_len_i   = CNT_W'(pl);
        if (rst) begin
            {mz, mc, mn, mv} = 4'b0000;
            m_act  = 1'b0;
            m_left = 0;
            m_err  = 1'b0;
        end
        eff  = (PRED && m_act) ? m_pc : c;
        mark = PRED && ps && !m_act;
        ex   = v && m_pass(eff) && !mark;
        #1;
        chk("ctrl_o", 8'(ctrl_o), 8'(ex ? ctl : 3'b000));
        chk("cond_ex_o", 8'(cond_ex_o), 8'(ex));
        chk("flags_o", 8'(flags_o), 8'({mz, mc, mn, mv}));
        chk("pred_active_o", 8'(pred_active_o), 8'(m_act));
        chk("pred_remaining_o", 8'(pred_remaining_o), 8'(m_left));
        chk("pred_err_o", 8'(pred_err_o), 8'(m_err));
        if (!rst) begin
            err_n = PRED && v && ps && m_act;
            if (ex && fw[1]) begin
                mz = af[3];
                mn = af[1];
            end
            if (ex && fw[0]) begin
                mc = af[2];
                mv = af[0];
            end
            if (PRED && m_act) begin
                if (v) begin
                    m_left--;
                    if (m_left == 0) m_act = 1'b0;
                end
            end else if (PRED && v && ps && pl != 0) begin
                m_act  = 1'b1;
                m_left = (pl > PRED_MAX) ? PRED_MAX : pl;
                m_pc   = pc;
            end
            m_err = err_n;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_pc  = 0;
        reset = 1'b1;
        valid_i = 1'b0;
        cond_i = 4'h0;
        alu_flags_i = 4'h0;
        flag_write_i = 2'b00;
        ctrl_i = 3'b000;
        pred_start_i = 1'b0;
        pred_cond_i = 4'h0;
        pred_len_i = '0;

        // Reset state: AL passes, EQ fails on cleared flags
        cycle(1, 1, 14, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        chk("t1_al_ctrl", 8'(ctrl_o), 8'h07);
        cycle(1, 1, 0, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        chk("t1_eq_ctrl", 8'(ctrl_o), 8'h00);
        cycle(0, 0, 0, 4'h0, 2'b00, 3'b000, 0, 0, 0);

        // Flag write then EQ/NE
        cycle(0, 1, 14, 4'b1000, 2'b11, 3'b111, 0, 0, 0);
        after_edge();
        chk("t2_flags", 8'(flags_o), 8'h08);
        cycle(0, 1, 0, 4'h0, 2'b00, 3'b101, 0, 0, 0);
        cycle(0, 1, 1, 4'h0, 2'b00, 3'b101, 0, 0, 0);

        // All 16 codes under 8 flag values
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 14, 4'((i * 5 + 3) % 16), 2'b11, 3'b001, 0, 0, 0);
            for (int k = 0; k < 16; k++)
                cycle(0, 1, k, 4'hF, 2'b00, 3'b111, 0, 0, 0);
        end

        // Failed condition must not write flags
        cycle(0, 1, 14, 4'b1000, 2'b11, 3'b000, 0, 0, 0);
        cycle(0, 1, 1, 4'b0000, 2'b11, 3'b111, 0, 0, 0);
        after_edge();
        chk("t3_flags_hold", 8'(flags_o), 8'h08);

        // Block of 3 under EQ with NE instructions, then plain NE
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b000, 1, 0, 3);
        for (int k = 0; k < 3; k++)
            cycle(0, 1, 1, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        cycle(0, 1, 1, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        chk("t4_active_drop", 8'(pred_active_o), 8'h00);

        // Oversized length, nested marker, stalls, zero-length marker
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b000, 1, 14, 7);
        cycle(0, 1, 0, 4'h0, 2'b00, 3'b011, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 2'b00, 3'b011, 0, 0, 0);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b011, 1, 0, 3);
        cycle(0, 1, 0, 4'h0, 2'b11, 3'b011, 0, 0, 0);
        cycle(0, 1, 0, 4'h0, 2'b00, 3'b011, 0, 0, 0);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b011, 1, 0, 0);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b011, 0, 0, 0);

        // Reset in the middle of a block
        cycle(0, 1, 14, 4'b0110, 2'b11, 3'b000, 0, 0, 0);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b000, 1, 14, 4);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        cycle(1, 0, 14, 4'h0, 2'b00, 3'b111, 0, 0, 0);
        chk("t6_rst_flags", 8'(flags_o), 8'h00);
        chk("t6_rst_active", 8'(pred_active_o), 8'h00);
        cycle(0, 1, 14, 4'h0, 2'b00, 3'b111, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15),
                  4'($urandom),
                  2'($urandom),
                  3'($urandom),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15),
                  $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
